// File: rtl/dcache_pkg.sv
// Shared definitions for dcache_burst: FSM state encoding and default geometry.
package dcache_pkg;

  localparam int DEF_ADDRBITS  = 32;
  localparam int DEF_DATABITS  = 32;
  localparam int DEF_LINES     = 8;
  localparam int DEF_LINEWORDS = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FILL  = 2'd1,
    ST_WRITE = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

endpackage

// File: rtl/dcache_burst_store.sv
// Tag/valid array plus word array for dcache_burst.
// One write port (word and/or tag+valid of a single line), combinational read.
module dcache_burst_store #(
  parameter int TAGBITS   = 25,
  parameter int DATABITS  = 32,
  parameter int LINES     = 8,
  parameter int LINEWORDS = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [$clog2(LINES)-1:0]     rd_index,
  input  logic [$clog2(LINEWORDS)-1:0] rd_off,
  output logic                         rd_valid,
  output logic [TAGBITS-1:0]           rd_tag,
  output logic [DATABITS-1:0]          rd_data,
  input  logic                         wr_word_en,
  input  logic                         wr_tag_en,
  input  logic [$clog2(LINES)-1:0]     wr_index,
  input  logic [$clog2(LINEWORDS)-1:0] wr_off,
  input  logic [DATABITS-1:0]          wr_data,
  input  logic                         wr_valid,
  input  logic [TAGBITS-1:0]           wr_tag
);

  logic [LINES-1:0]    valid_q;
  logic [TAGBITS-1:0]  tag_q  [LINES];
  logic [DATABITS-1:0] word_q [LINES*LINEWORDS];

  always_ff @(posedge clk) begin
    if (reset)
      valid_q <= '0;
    else if (wr_tag_en)
      valid_q[wr_index] <= wr_valid;
  end

  always_ff @(posedge clk) begin
    if (wr_tag_en)
      tag_q[wr_index] <= wr_tag;
    if (wr_word_en)
      word_q[{wr_index, wr_off}] <= wr_data;
  end

  assign rd_valid = valid_q[rd_index];
  assign rd_tag   = tag_q[rd_index];
  assign rd_data  = word_q[{rd_index, rd_off}];

endmodule

// File: rtl/dcache_burst.sv
// Direct-mapped, write-through, no-write-allocate data cache with burst line fill.
// Optional hit/miss counters are built when DCACHE_STATS_EN is defined.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | accept a request; read hits load the data directly
// ST_FILL  | burst-read the line from memory, one word per mem_valid
// ST_WRITE | write-through to memory, wait for the acknowledge
// ST_RESP  | one-cycle dcache_valid, then back to IDLE
module dcache_burst
  import dcache_pkg::*;
#(
  parameter int ADDRBITS  = DEF_ADDRBITS,
  parameter int DATABITS  = DEF_DATABITS,
  parameter int LINES     = DEF_LINES,
  parameter int LINEWORDS = DEF_LINEWORDS
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [ADDRBITS-1:0] dcache_addr,
  input  logic [DATABITS-1:0] dcache_datain,
  input  logic                dcache_rdreq,
  input  logic                dcache_wrreq,
  output logic [DATABITS-1:0] dcache_dataout,
  output logic                dcache_valid,
  output logic                dcache_busy,
  output logic [ADDRBITS-1:0] mem_addr,
  output logic [DATABITS-1:0] mem_datain,
  output logic                mem_rdreq,
  output logic                mem_wrreq,
  output logic [15:0]         mem_burstlen,
  input  logic [DATABITS-1:0] mem_out,
  input  logic                mem_valid
`ifdef DCACHE_STATS_EN
  ,
  output logic [31:0]         stat_hits,
  output logic [31:0]         stat_misses
`endif
);

  localparam int OB      = $clog2(LINEWORDS);
  localparam int IB      = $clog2(LINES);
  localparam int TAGBITS = ADDRBITS - 2 - OB - IB;

  state_t state, state_nxt;

  logic [OB-1:0]       in_off, req_off, beats_left, beat_off, st_wr_off;
  logic [IB-1:0]       in_index, req_index, st_wr_index;
  logic [TAGBITS-1:0]  in_tag, req_tag, st_rd_tag;
  logic [DATABITS-1:0] st_rd_data, st_wr_data, dataout_q, mem_datain_q;
  logic [ADDRBITS-1:0] mem_addr_q;
  logic                st_rd_valid, st_word_en, st_tag_en;
  logic                hit, wr_go, rd_go, fill_beat, rd_pending;

  assign in_off   = dcache_addr[2 +: OB];
  assign in_index = dcache_addr[2+OB +: IB];
  assign in_tag   = dcache_addr[ADDRBITS-1 -: TAGBITS];

  assign hit       = st_rd_valid && (st_rd_tag == in_tag);
  assign wr_go     = (state == ST_IDLE) && dcache_wrreq;
  assign rd_go     = (state == ST_IDLE) && dcache_rdreq && !dcache_wrreq;
  assign fill_beat = (state == ST_FILL) && mem_valid;
  // beats_left counts down from LINEWORDS-1, so its complement is the beat index
  assign beat_off  = ~beats_left;

  always_ff @(posedge clk) begin
    if (reset)
      state <= ST_IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE: begin
        if (wr_go)
          state_nxt = ST_WRITE;
        else if (rd_go)
          state_nxt = hit ? ST_RESP : ST_FILL;
      end
      ST_FILL:  if (mem_valid && beats_left == '0) state_nxt = ST_RESP;
      ST_WRITE: if (mem_valid) state_nxt = ST_RESP;
      ST_RESP:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    dcache_busy  = (state != ST_IDLE);
    dcache_valid = (state == ST_RESP);
    mem_wrreq    = (state == ST_WRITE);
    mem_rdreq    = (state == ST_FILL) && rd_pending;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      dataout_q    <= '0;
      mem_addr_q   <= '0;
      mem_datain_q <= '0;
      req_off      <= '0;
      req_index    <= '0;
      req_tag      <= '0;
      beats_left   <= '0;
      rd_pending   <= 1'b0;
    end else begin
      if (wr_go) begin
        mem_addr_q   <= dcache_addr;
        mem_datain_q <= dcache_datain;
      end else if (rd_go) begin
        req_off   <= in_off;
        req_index <= in_index;
        req_tag   <= in_tag;
        if (hit) begin
          dataout_q <= st_rd_data;
        end else begin
          mem_addr_q <= {dcache_addr[ADDRBITS-1:OB+2], {(OB+2){1'b0}}};
          rd_pending <= 1'b1;
          beats_left <= '1;
        end
      end
      if (fill_beat) begin
        rd_pending <= 1'b0;
        beats_left <= beats_left - 1'b1;
        if (beat_off == req_off)
          dataout_q <= mem_out;
      end
    end
  end

  // The first beat invalidates the line so a partly refilled line never hits
  assign st_word_en  = fill_beat || (wr_go && hit);
  assign st_tag_en   = fill_beat && (beats_left == '1 || beats_left == '0);
  assign st_wr_index = fill_beat ? req_index : in_index;
  assign st_wr_off   = fill_beat ? beat_off  : in_off;
  assign st_wr_data  = fill_beat ? mem_out   : dcache_datain;

  dcache_burst_store #(
    .TAGBITS  (TAGBITS),
    .DATABITS (DATABITS),
    .LINES    (LINES),
    .LINEWORDS(LINEWORDS)
  ) u_store (
    .clk       (clk),
    .reset     (reset),
    .rd_index  (in_index),
    .rd_off    (in_off),
    .rd_valid  (st_rd_valid),
    .rd_tag    (st_rd_tag),
    .rd_data   (st_rd_data),
    .wr_word_en(st_word_en),
    .wr_tag_en (st_tag_en),
    .wr_index  (st_wr_index),
    .wr_off    (st_wr_off),
    .wr_data   (st_wr_data),
    .wr_valid  (beats_left == '0),
    .wr_tag    (req_tag)
  );

  assign dcache_dataout = dataout_q;
  assign mem_addr       = mem_addr_q;
  assign mem_datain     = mem_datain_q;
  assign mem_burstlen   = 16'(LINEWORDS);

`ifdef DCACHE_STATS_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      stat_hits   <= '0;
      stat_misses <= '0;
    end else if (rd_go) begin
      if (hit && stat_hits != '1)
        stat_hits <= stat_hits + 1'b1;
      else if (!hit && stat_misses != '1)
        stat_misses <= stat_misses + 1'b1;
    end
  end
`endif

endmodule
